// File: rtl/real_dom_shared_mul_gfn.sv
// Domain-oriented masked GF(2^N) multiplier with a 1-cycle valid/ready stage.
// Optional macro DOM_OUTPUT_REGISTER_EN adds a registered output-share stage (2-cycle latency).
module real_dom_shared_mul_gfn #(
    parameter int           N      = 2,
    parameter int           SHARES = 2,
    parameter logic [N-1:0] POLY   = 2'b11
) (
    input  logic                                ClkxCI,
    input  logic                                RstxRI,
    input  logic [N*SHARES-1:0]                 XxDI,
    input  logic [N*SHARES-1:0]                 YxDI,
    input  logic [N*SHARES*(SHARES-1)/2-1:0]    ZxDI,
    input  logic                                ValidxSI,
    output logic                                ReadyxSO,
    output logic [N*SHARES-1:0]                 QxDO,
    output logic                                ValidxSO,
    input  logic                                ReadyxSI
);

    localparam int D = SHARES;

    function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] acc;
        logic [N-1:0] aa;
        acc = '0;
        aa  = a;
        for (int i = 0; i < N; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = aa[N-1] ? ((aa << 1) ^ POLY) : (aa << 1);
        end
        return acc;
    endfunction

    function automatic int zidx(input int i, input int j);
        return i*D - (i*(i+1))/2 + (j-i-1);
    endfunction

    logic [N-1:0]   term_d [D][D];
    logic [N-1:0]   s1_q   [D][D];
    logic           valid1_q;
    logic           transfer;
    logic           drain1;
    logic [N*D-1:0] qrow;

    // Cross-domain terms are remasked before their register so no two domains meet unmasked.
    always_comb begin
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                term_d[i][j] = gf_mul(XxDI[i*N +: N], YxDI[j*N +: N]);
                if (i < j)
                    term_d[i][j] = term_d[i][j] ^ ZxDI[zidx(i, j)*N +: N];
                else if (i > j)
                    term_d[i][j] = term_d[i][j] ^ ZxDI[zidx(j, i)*N +: N];
            end
        end
    end

    always_comb begin
        qrow = '0;
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                qrow[i*N +: N] = qrow[i*N +: N] ^ s1_q[i][j];
            end
        end
    end

    assign transfer = ValidxSI && ReadyxSO;

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            valid1_q <= 1'b0;
            for (int i = 0; i < D; i++)
                for (int j = 0; j < D; j++)
                    s1_q[i][j] <= '0;
        end else if (transfer) begin
            valid1_q <= 1'b1;
            for (int i = 0; i < D; i++)
                for (int j = 0; j < D; j++)
                    s1_q[i][j] <= term_d[i][j];
        end else if (drain1) begin
            valid1_q <= 1'b0;
        end
    end

`ifdef DOM_OUTPUT_REGISTER_EN
    logic           valid2_q;
    logic [N*D-1:0] q2_q;
    logic           ready2;

    assign ready2   = !valid2_q || ReadyxSI;
    assign drain1   = ready2;
    assign ReadyxSO = !valid1_q || ready2;
    assign QxDO     = q2_q;
    assign ValidxSO = valid2_q;

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            valid2_q <= 1'b0;
            q2_q     <= '0;
        end else if (ready2) begin
            valid2_q <= valid1_q;
            if (valid1_q) q2_q <= qrow;
        end
    end
`else
    assign drain1   = ReadyxSI;
    assign ReadyxSO = !valid1_q || ReadyxSI;
    assign QxDO     = qrow;
    assign ValidxSO = valid1_q;
`endif

endmodule

// File: doc/real_dom_shared_mul_gfn.md
REAL_DOM_SHARED_MUL_GFN -- requirements
Module: real_dom_shared_mul_gfn

Interface
REQ-001 SHALL have parameter N, default 2: field width in bits; GF(2^N) elements; legal range 2..8.
REQ-002 SHALL have parameter SHARES, default 2: number of DOM shares D; legal range 2..4.
REQ-003 SHALL have parameter POLY, default 2'b11: low N bits of the irreducible reduction polynomial; the x^N term is implicit.
REQ-004 SHALL have port ClkxCI, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port RstxRI, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port XxDI, input, N*D bits: shares of X; share i occupies bits [i*N +: N].
REQ-007 SHALL have port YxDI, input, N*D bits: shares of Y, packed the same way as XxDI.
REQ-008 SHALL have port ZxDI, input, N*D(D-1)/2 bits: fresh masks; mask for pair (i<j) at index k = i*D - i(i+1)/2 + (j-i-1).
REQ-009 SHALL have port ValidxSI, input, 1 bit: X, Y and Z inputs are valid this cycle.
REQ-010 SHALL have port ReadyxSO, output, 1 bit: the block accepts an input this cycle.
REQ-011 SHALL have port QxDO, output, N*D bits: shares of the product Q = X*Y in GF(2^N).
REQ-012 SHALL have port ValidxSO, output, 1 bit: QxDO is valid this cycle.
REQ-013 SHALL have port ReadyxSI, input, 1 bit: the downstream side accepts QxDO this cycle.

Function
REQ-014 SHALL implement multiplication as polynomial-basis GF(2^N) multiplication reduced by x^N + POLY.
REQ-015 SHALL accept an input ("transfer") in any cycle where ValidxSI and ReadyxSO are both 1; ZxDI is consumed only on a transfer.
REQ-016 SHALL, on each transfer, register every inner-domain term x_i*y_i and every cross-domain term x_i*y_j ^ z_(min(i,j),max(i,j)) for i!=j into stage-1 registers, giving D*D registers of N bits each.
REQ-017 SHALL form output share q_i combinationally as the XOR of the stage-1 registers of row i only; no term from another domain may be combined before its register.
REQ-018 SHALL, with a correct implementation, ensure the XOR of all q_i equals X*Y, where X and Y are the XOR of their respective shares.
REQ-019 SHALL have a latency of 1 cycle: data transferred at edge t is presented with ValidxSO=1 after edge t.
REQ-020 SHALL drive ReadyxSO = !ValidxSO || ReadyxSI, so a full throughput of one product per cycle is possible.
REQ-021 SHALL hold stage registers and ValidxSO unchanged while ValidxSO=1 and ReadyxSI=0 (stall); QxDO SHALL then remain bit-stable.
REQ-022 SHALL, when an output is taken and a new input transfers in the same cycle, load the new data with ValidxSO remaining 1.
REQ-023 SHALL, when an output is taken and no input transfers, clear ValidxSO to 0 after the edge; the stage registers keep their old data.
REQ-024 SHALL ignore XxDI, YxDI and ZxDI whenever no transfer occurs.

Reset
REQ-025 SHALL, on any edge with RstxRI=1, clear ValidxSO and all stage registers to 0, including any in-flight or stalled product, which is dropped.
REQ-026 SHALL drive, during reset, QxDO=0, ValidxSO=0 and ReadyxSO=1.
REQ-027 SHALL give reset priority over a simultaneous transfer; the input presented on that edge is discarded.

Configuration
REQ-028 SHALL, when the macro DOM_OUTPUT_REGISTER_EN is defined, add a per-share output register stage holding q_i, and a second valid bit.
REQ-029 SHALL, with DOM_OUTPUT_REGISTER_EN defined, have a latency of 2 cycles, drive QxDO directly from flops, and use the same ready rule per stage: stage 1 advances when stage 2 is empty or being drained.
REQ-030 SHALL, with DOM_OUTPUT_REGISTER_EN undefined, behave exactly per REQ-017 to REQ-023.

Verification
REQ-031 SHALL verify the basic product with N=2, D=2: X shares (1,3), Y shares (2,1), Z=2, ValidxSI=1, ReadyxSI=1 -> after 1 edge, ValidxSO=1 and q0^q1 = 1 (2*3 in GF(4)).
REQ-032 SHALL verify the zero operand: X shares (3,3), any Y, any Z -> q0^q1 = 0.
REQ-033 SHALL verify a stall: hold ReadyxSI=0 for 3 cycles after a valid product -> ReadyxSO=0, and QxDO and ValidxSO are unchanged every cycle; release -> the next input is accepted on the same edge.
REQ-034 SHALL verify back-to-back throughput: 16 random transfers with ReadyxSI=1 throughout -> 16 consecutive valid outputs, each matching a reference GF multiply.
REQ-035 SHALL verify reset during a stall: assert RstxRI with ValidxSO=1 -> after the edge, ValidxSO=0, QxDO=0 and ReadyxSO=1.
REQ-036 SHALL verify N=4, D=3, POLY=4'b0011 with 1000 random inputs -> the XOR of the output shares equals X*Y mod x^4+x+1, both with and without DOM_OUTPUT_REGISTER_EN.
